// File: rtl/parity_frame_rx_if.sv
// Serial line in, decoded frame and status out.
// slave = receiver side, master = line driver / frame consumer.
interface parity_frame_rx_if #(
  parameter int DATA_W = 8
);
  logic              x;
  logic              en;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  modport slave (
    input  x, en,
    output data, valid, parity_err, frame_err, busy
  );

  modport master (
    output x, en,
    input  data, valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/parity_frame_rx.sv
// Strobed serial frame receiver: start, LSB-first data, parity, stop.
// Flags and data are registered together with a one-cycle valid pulse.
module parity_frame_rx #(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic clk,
  input  logic rst,
  parity_frame_rx_if.slave bus
);
  localparam int CW = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              par_q, par_d;
  logic              perr_q, perr_d;
  logic [DATA_W-1:0] shr_q, shr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              pe_q, pe_d;
  logic              fe_q, fe_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    perr_d  = perr_q;
    shr_d   = shr_q;
    data_d  = data_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    valid_d = 1'b0;
    if (bus.en) begin
      unique case (state_q)
        IDLE: begin
          if (!bus.x) begin
            state_d = DATA;
            cnt_d   = '0;
            par_d   = 1'b0;
          end
        end
        DATA: begin
          for (int i = 0; i < DATA_W; i++) begin
            if (cnt_q == CW'(i)) shr_d[i] = bus.x;
          end
          par_d = par_q ^ bus.x;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_W - 1)) state_d = PARITY;
        end
        PARITY: begin
          perr_d  = bus.x ^ par_q ^ ODD_PARITY;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          data_d  = shr_q;
          pe_d    = perr_q;
          fe_d    = ~bus.x;
          valid_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      shr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      perr_q  <= perr_d;
      shr_q   <= shr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
    end
  end

  assign bus.data       = data_q;
  assign bus.valid      = valid_q;
  assign bus.parity_err = pe_q;
  assign bus.frame_err  = fe_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench: even-parity receiver (a) and odd-parity receiver (b).
// Expected values are hand-computed per frame.
module tb_parity_frame_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   vcnt_a = 0;
  int   vcnt_b = 0;

  always #5 clk = ~clk;

  parity_frame_rx_if #(.DATA_W(8)) a ();
  parity_frame_rx_if #(.DATA_W(8)) b ();

  parity_frame_rx #(.DATA_W(8), .ODD_PARITY(1'b0)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (a.slave)
  );

  parity_frame_rx #(.DATA_W(8), .ODD_PARITY(1'b1)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  always @(posedge clk) begin
    if (a.valid) vcnt_a = vcnt_a + 1;
    if (b.valid) vcnt_b = vcnt_b + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_a(input logic v, input bit sparse);
    if (sparse) begin
      repeat (3) begin
        a.en = 1'b0;
        a.x  = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
    a.en = 1'b1;
    a.x  = v;
    @(posedge clk); #1;
  endtask

  task automatic frame_a(input string tag,
                         input logic [7:0] d,
                         input logic p,
                         input logic s,
                         input bit sparse,
                         input logic exp_pe,
                         input logic exp_fe);
    int v0;
    v0 = vcnt_a;
    bit_a(1'b0, sparse);
    check({tag, "_busy_mid"}, 32'(a.busy), 32'd1);
    for (int i = 0; i < 8; i++) bit_a(d[i], sparse);
    bit_a(p, sparse);
    check({tag, "_novalid_pre"}, 32'(a.valid), 32'd0);
    bit_a(s, sparse);
    check({tag, "_valid"}, 32'(a.valid), 32'd1);
    check({tag, "_data"}, 32'(a.data), 32'(d));
    check({tag, "_perr"}, 32'(a.parity_err), 32'(exp_pe));
    check({tag, "_ferr"}, 32'(a.frame_err), 32'(exp_fe));
    check({tag, "_busy_end"}, 32'(a.busy), 32'd0);
    a.en = 1'b0;
    a.x  = 1'b1;
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, 32'(a.valid), 32'd0);
    check({tag, "_pulses"}, 32'(vcnt_a - v0), 32'd1);
    check({tag, "_data_hold"}, 32'(a.data), 32'(d));
  endtask

  initial begin
    logic [7:0] f;
    int v0;
    a.x = 1'b1; a.en = 1'b0;
    b.x = 1'b1; b.en = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", 32'(a.data), 32'd0);
    check("rst_valid", 32'(a.valid), 32'd0);
    check("rst_perr", 32'(a.parity_err), 32'd0);
    check("rst_ferr", 32'(a.frame_err), 32'd0);
    check("rst_busy", 32'(a.busy), 32'd0);
    check("rst_busy_b", 32'(b.busy), 32'd0);
    rst = 1'b0;
    a.en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", 32'(a.busy), 32'd0);

    frame_a("a5_ok", 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    frame_a("a5_pe", 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    frame_a("a5_fe", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    frame_a("3c_ok", 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Abort a 0x3C frame after four data bits.
    f  = 8'h3C;
    v0 = vcnt_a;
    bit_a(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) bit_a(f[i], 1'b0);
    check("abort_busy_pre", 32'(a.busy), 32'd1);
    rst  = 1'b1;
    a.en = 1'b1;
    a.x  = 1'b0;
    @(posedge clk); #1;
    rst  = 1'b0;
    a.x  = 1'b1;
    check("abort_busy", 32'(a.busy), 32'd0);
    check("abort_data", 32'(a.data), 32'd0);
    check("abort_valid", 32'(a.valid), 32'd0);
    @(posedge clk); #1;
    check("abort_nopulse", 32'(vcnt_a - v0), 32'd0);
    frame_a("3c_after_rst", 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    frame_a("a5_sparse", 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Odd-parity receiver: 0x00 with parity bit 1, then idle line.
    f  = 8'h00;
    v0 = vcnt_b;
    b.en = 1'b1;
    b.x  = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      b.x = f[i];
      @(posedge clk); #1;
    end
    b.x = 1'b1;
    @(posedge clk); #1;
    b.x = 1'b1;
    @(posedge clk); #1;
    check("odd_valid", 32'(b.valid), 32'd1);
    check("odd_data", 32'(b.data), 32'd0);
    check("odd_perr", 32'(b.parity_err), 32'd0);
    check("odd_ferr", 32'(b.frame_err), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("odd_pulses", 32'(vcnt_b - v0), 32'd1);
    check("odd_busy", 32'(b.busy), 32'd0);
    check("odd_valid_low", 32'(b.valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/parity_frame_rx.md
PARITY_FRAME_RX -- requirements
Module: parity_frame_rx

Interface
REQ-001: Parameter DATA_W, default 8, number of data bits per frame (legal range 1..16).
REQ-002: Parameter ODD_PARITY, default 0, parity sense: 0 = even, 1 = odd.
REQ-003: clk  input  1  rising-edge clock, sole clock domain.
REQ-004: rst  input  1  synchronous, active-high reset.
REQ-005: x  input  1  serial line bit, idle level 1.
REQ-006: en  input  1  bit strobe; x sampled only on clk edges where en=1.
REQ-007: data  output  DATA_W  last received data word, LSB first on line.
REQ-008: valid  output  1  one-cycle pulse, frame complete.
REQ-009: parity_err  output  1  parity mismatch for the frame flagged by valid.
REQ-010: frame_err  output  1  stop bit sampled 0 for the frame flagged by valid.
REQ-011: busy  output  1  high while a frame is in progress (state != IDLE).

Function
REQ-012: Frame format SHALL be: start bit 0, DATA_W data bits (LSB first), 1 parity bit, stop bit 1.
REQ-013: FSM states SHALL be IDLE, DATA, PARITY, STOP; all transitions occur only on edges with en=1.
REQ-014: IDLE: en=1 & x=0 -> DATA, bit counter=0, running parity=0; en=1 & x=1 -> stay IDLE.
REQ-015: DATA: each en=1 edge stores x at data bit [counter], XORs x into running parity, increments counter.
REQ-016: DATA -> PARITY on the edge sampling data bit DATA_W-1; counter width ceil(log2(DATA_W))+1, no wrap.
REQ-017: PARITY: on en=1, capture parity_err_next = x XOR running parity XOR ODD_PARITY; -> STOP.
REQ-018: STOP: on en=1, go to IDLE; on that same edge register data, parity_err, frame_err (=~x), and set valid=1.
REQ-019: valid SHALL be high exactly one clk cycle per frame, regardless of error flags.
REQ-020: data, parity_err, frame_err SHALL hold their values until the next valid pulse.
REQ-021: Frame with stop bit 0 SHALL still return to IDLE; no resync/break detection.
REQ-022: en=0 cycles SHALL hold all state, counters and outputs (except valid, which SHALL drop to 0).
REQ-023: Start bit detected in the same edge as STOP->IDLE is not possible; first IDLE sample occurs on next en=1 edge.
REQ-024: busy SHALL be combinational from state: 0 in IDLE, 1 otherwise.
REQ-025: Latency: valid rises on the clk edge that samples the stop bit, observable in the following cycle.

Reset
REQ-026: rst=1 SHALL dominate en; on that edge state=IDLE, counter=0, running parity=0.
REQ-027: Reset values: data=0, valid=0, parity_err=0, frame_err=0, busy=0.
REQ-028: Reset mid-frame SHALL discard the partial frame with no valid pulse; first frame after rst decodes normally.

Verification
REQ-029: DATA_W=8, even; en=1 every cycle, bits 0,1,0,1,0,0,1,0,1,0,1 (0xA5, parity 0, stop 1) -> one valid pulse, data=0xA5, parity_err=0, frame_err=0.
REQ-030: Same frame with parity bit 1 -> valid pulse, data=0xA5, parity_err=1, frame_err=0.
REQ-031: Same frame with stop bit 0 -> valid pulse, data=0xA5, frame_err=1; following 0x3C frame decodes with both flags 0.
REQ-032: rst asserted after 4 data bits of a frame, then full 0x3C frame (parity 0) -> no pulse for aborted frame, data=0x3C, busy=0 after reset.
REQ-033: 0xA5 frame with en high one cycle in four, x toggled randomly in en=0 cycles -> identical result to REQ-029, valid width exactly 1 cycle.
REQ-034: ODD_PARITY=1, frame 0x00 with parity bit 1; then x=1 for 20 en cycles -> valid, data=0x00, parity_err=0; no further valid, busy=0.
